// File: rtl/mbyte_add_seq_if.sv
// mbyte_add_seq_if: requester/consumer bus of the multi-byte add sequencer.
//   master : requester side (drives in_valid, op_*, out_ready)
//   slave  : sequencer side (drives in_ready, out_valid, result, cout[, ovf])
// Optional: define MBYTE_ADD_OVF_EN to add the signed-overflow flag ovf.
interface mbyte_add_seq_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NBYTES = 4
);
    localparam int unsigned DW = WIDTH * NBYTES;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          op_cin;
    logic          op_sub;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] result;
    logic          cout;
`ifdef MBYTE_ADD_OVF_EN
    logic          ovf;

    modport master (
        output in_valid, op_a, op_b, op_cin, op_sub, out_ready,
        input  in_ready, out_valid, result, cout, ovf
    );

    modport slave (
        input  in_valid, op_a, op_b, op_cin, op_sub, out_ready,
        output in_ready, out_valid, result, cout, ovf
    );
`else
    modport master (
        output in_valid, op_a, op_b, op_cin, op_sub, out_ready,
        input  in_ready, out_valid, result, cout
    );

    modport slave (
        input  in_valid, op_a, op_b, op_cin, op_sub, out_ready,
        output in_ready, out_valid, result, cout
    );
`endif
endinterface

// File: rtl/mbyte_add_seq.sv
// mbyte_add_seq: runs NBYTES*WIDTH-bit add/subtract through one shared
// WIDTH-bit combinational adder, one byte per clock, LSB first, carry chained.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   bus (slave)       valid/ready operand request and result handoff
//   add_a/add_b/add_cin  byte operands and carry toward the shared adder
//                        (combinational from registers, 0 outside RUN)
//   add_sum/add_cout  shared adder response
// Optional: define MBYTE_ADD_OVF_EN to produce bus.ovf (signed overflow).
module mbyte_add_seq #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NBYTES = 4
) (
    input  logic             clk,
    input  logic             rst,
    mbyte_add_seq_if.slave   bus,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH:0]   add_sum,
    input  logic             add_cout
);
    localparam int unsigned DW       = WIDTH * NBYTES;
    localparam int unsigned IDX_W    = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [DW-1:0]    opa_q;
    logic [DW-1:0]    opb_q;
    logic             carry_q;
    logic [DW-1:0]    result_q;
    logic             cout_q;
    logic             in_ready_q;
    logic             out_valid_q;

    // The chained carry comes from add_cout; the sum MSB is redundant with it.
    logic unused_sum_msb;
    assign unused_sum_msb = add_sum[WIDTH];

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;

    // Byte idx of the latched operands toward the adder; quiet outside RUN.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = opa_q[idx*WIDTH +: WIDTH];
            add_b   = opb_q[idx*WIDTH +: WIDTH];
            add_cin = carry_q;
        end
    end

`ifdef MBYTE_ADD_OVF_EN
    logic ovf_q;
    logic msb_cin;

    assign bus.ovf = ovf_q;

    // Carry into the top bit, recovered from the top bit's sum equation.
    assign msb_cin = add_a[WIDTH-1] ^ add_b[WIDTH-1] ^ add_sum[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state == RUN && idx == LAST_IDX) begin
            ovf_q <= msb_cin ^ add_cout;
        end
    end
`endif

    // Sequencer: accept, one byte per cycle, hold result until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        opa_q      <= bus.op_a;
                        // Subtract as A + ~B + 1: invert B once here, force carry-in.
                        opb_q      <= bus.op_sub ? ~bus.op_b : bus.op_b;
                        carry_q    <= bus.op_sub ? 1'b1 : bus.op_cin;
                        idx        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    result_q[idx*WIDTH +: WIDTH] <= add_sum[WIDTH-1:0];
                    carry_q <= add_cout;
                    if (idx == LAST_IDX) begin
                        cout_q      <= add_cout;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    // No bypass: in_ready rises only after the handoff edge.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mbyte_add_seq.sv
// tb_mbyte_add_seq: directed bench for mbyte_add_seq with a behavioural
// shared adder and a queue of expected results built from a wide model.
module tb_mbyte_add_seq;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned NBYTES = 4;
    localparam int unsigned DW     = WIDTH * NBYTES;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mbyte_add_seq_if #(.WIDTH(WIDTH), .NBYTES(NBYTES)) bus ();

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH:0]   add_sum;
    logic             add_cout;

    // The existing combinational adder the sequencer shares.
    assign add_sum  = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    assign add_cout = add_sum[WIDTH];

    mbyte_add_seq #(.WIDTH(WIDTH), .NBYTES(NBYTES)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    typedef struct {
        logic [DW-1:0] res;
        logic          cout;
        logic          ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic cin, input logic sub);
        exp_t          e;
        logic [DW-1:0] bb;
        logic [DW:0]   w;
        bb     = sub ? ~b : b;
        w      = {1'b0, a} + {1'b0, bb} + {{DW{1'b0}}, (sub ? 1'b1 : cin)};
        e.res  = w[DW-1:0];
        e.cout = w[DW];
        e.ovf  = (a[DW-1] == bb[DW-1]) && (e.res[DW-1] != a[DW-1]);
        return e;
    endfunction

    task automatic drive(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic cin, input logic sub);
        bus.op_a     = a;
        bus.op_b     = b;
        bus.op_cin   = cin;
        bus.op_sub   = sub;
        bus.in_valid = 1'b1;
    endtask

    // Wait for in_ready, record the expectation, take the accept edge,
    // then scramble the operand inputs to prove they were latched.
    task automatic accept(output int waited);
        int i = 0;
        while (bus.in_ready !== 1'b1 && i < 40) begin
            tick();
            i++;
        end
        check("accept_timeout", DW'(i < 40), DW'(1));
        sb.push_back(model(bus.op_a, bus.op_b, bus.op_cin, bus.op_sub));
        tick();
        bus.in_valid = 1'b0;
        bus.op_a     = ~bus.op_a;
        bus.op_b     = ~bus.op_b;
        bus.op_sub   = ~bus.op_sub;
        bus.op_cin   = ~bus.op_cin;
        waited = i;
    endtask

    // Called right after the accept edge; checks latency and the result.
    task automatic collect(output exp_t e);
        int lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            check("busy_in_ready", DW'(bus.in_ready), DW'(0));
            tick();
            lat++;
        end
        check("latency", DW'(lat), DW'(NBYTES));
        check("sb_nonempty", DW'(sb.size() != 0), DW'(1));
        e = sb.pop_front();
        check("result", bus.result, e.res);
        check("cout", DW'(bus.cout), DW'(e.cout));
`ifdef MBYTE_ADD_OVF_EN
        check("ovf", DW'(bus.ovf), DW'(e.ovf));
`endif
        if (bus.out_ready) begin
            tick();
            check("handoff_out_valid", DW'(bus.out_valid), DW'(0));
            check("handoff_in_ready", DW'(bus.in_ready), DW'(1));
        end
    endtask

    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic cin, input logic sub);
        int   w;
        exp_t e;
        drive(a, b, cin, sub);
        accept(w);
        collect(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w;
        exp_t e;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.op_a     = '0;
        bus.op_b     = '0;
        bus.op_cin   = 1'b0;
        bus.op_sub   = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", DW'(bus.in_ready), DW'(1));
        check("rst_out_valid", DW'(bus.out_valid), DW'(0));
        check("rst_result", bus.result, DW'(0));
        check("rst_cout", DW'(bus.cout), DW'(0));
        check("rst_add_a", DW'(add_a), DW'(0));
        check("rst_add_b", DW'(add_b), DW'(0));
        check("rst_add_cin", DW'(add_cin), DW'(0));
`ifdef MBYTE_ADD_OVF_EN
        check("rst_ovf", DW'(bus.ovf), DW'(0));
`endif

        // First op, with a look at the byte-0 adder drive
        drive(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        accept(w);
        check("byte0_add_a", DW'(add_a), DW'(8'hFF));
        check("byte0_add_b", DW'(add_b), DW'(8'h01));
        check("byte0_add_cin", DW'(add_cin), DW'(0));
        collect(e);
        check("plan_add_res", e.res, 32'h0000_0100);

        // Full carry chain and subtract
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
        drive(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
        accept(w);
        check("sub_byte0_add_b", DW'(add_b), DW'(8'hF8));
        check("sub_byte0_add_cin", DW'(add_cin), DW'(1));
        collect(e);
        run_op(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1);

        // Backpressure with a second request waiting
        bus.out_ready = 1'b0;
        drive(32'h0102_0304, 32'h1020_3040, 1'b0, 1'b0);
        accept(w);
        collect(e);
        drive(32'h0000_1000, 32'h0000_0234, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_out_valid", DW'(bus.out_valid), DW'(1));
            check("bp_in_ready", DW'(bus.in_ready), DW'(0));
            check("bp_result", bus.result, e.res);
            check("bp_cout", DW'(bus.cout), DW'(e.cout));
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_handoff_out_valid", DW'(bus.out_valid), DW'(0));
        check("bp_handoff_in_ready", DW'(bus.in_ready), DW'(1));
        accept(w);
        check("bp_accept_wait", DW'(w), DW'(0));
        check("bp_accepted", DW'(bus.in_ready), DW'(0));
        collect(e);

        // Reset during RUN byte 2 discards the operation
        drive(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 1'b0);
        accept(w);
        tick();
        tick();
        check("mid_run_add_a", DW'(add_a), DW'(8'hAD));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb.pop_back());
        check("mrst_in_ready", DW'(bus.in_ready), DW'(1));
        check("mrst_out_valid", DW'(bus.out_valid), DW'(0));
        check("mrst_result", bus.result, DW'(0));
        check("mrst_add_a", DW'(add_a), DW'(0));
        for (int k = 0; k < 4; k++) begin
            tick();
            check("mrst_no_pulse", DW'(bus.out_valid), DW'(0));
        end
        drive(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        accept(w);
        collect(e);
        check("plan_post_rst_res", e.res, 32'h2345_6789);

        // Signed overflow boundaries (ovf checked when the feature is built)
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);

        // Random mix
        for (int k = 0; k < 8; k++) begin
            run_op(DW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
        end

        check("sb_empty", DW'(sb.size()), DW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mbyte_add_seq.md
Name: mbyte_add_seq

Overview:
- Sequencer that runs multi-byte add/subtract operations through one shared WIDTH-bit ripple adder, one byte per clock, least significant byte first, with the carry chained between bytes.
- Sits between a requester (valid/ready operand interface) and the existing combinational WIDTH-bit adder, which it drives through dedicated add_* ports.
- Gives NBYTES*WIDTH-bit arithmetic without widening the adder.

Parameters:
- WIDTH, 8, byte width of the shared adder.
- NBYTES, 4, number of bytes per operand; minimum 2. Counter width is clog2(NBYTES).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  block can accept an operation.
- op_a  input  WIDTH*NBYTES  operand A.
- op_b  input  WIDTH*NBYTES  operand B.
- op_cin  input  1  carry-in for add; ignored for sub.
- op_sub  input  1  0 = A+B+cin; 1 = A-B, computed as A+~B+1.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH*NBYTES  sum or difference.
- cout  output  1  final carry out; for sub, 1 = no borrow.
- add_a  output  WIDTH  byte to the adder a input.
- add_b  output  WIDTH  byte to the adder b input, already inverted for sub.
- add_cin  output  1  carry to the adder.
- add_sum  input  WIDTH+1  adder sum; bits [WIDTH-1:0] give the byte result.
- add_cout  input  1  adder carry out, used as the chained carry.

Behaviour:
- Reset values: in_ready=1, out_valid=0, result=0, cout=0, add_a=0, add_b=0, add_cin=0, FSM=IDLE, byte index=0, carry=0.

FSM states and transitions:
- IDLE:
  - in_ready=1.
  - When in_valid&in_ready, latch op_a, op_b (inverted if op_sub) and op_sub.
  - Latch carry = op_sub ? 1 : op_cin.
  - Set idx=0 and go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, add_a/add_b drive byte idx of the latched operands and add_cin drives the carry register.
  - On the clock edge, write add_sum[WIDTH-1:0] into result byte idx and load carry<=add_cout.
  - If idx==NBYTES-1, go to DONE; otherwise idx<=idx+1.
- DONE:
  - out_valid=1 and cout=final carry.
  - result and cout hold stable while out_ready=0.
  - When out_ready=1, go to IDLE with out_valid<=0.
  - in_ready returns to 1 in the following cycle. There is no bypass: a new operation is never accepted in the same cycle as the result handoff.

Latency:
- Accept at edge E0.
- RUN occupies cycles E0..E0+NBYTES-1.
- out_valid is high starting right after edge E0+NBYTES.
- Throughput is one operation per NBYTES+2 cycles when out_ready is held high.

Further rules:
- add_* outputs are combinational from registers. They drive 0 outside RUN.
- Latched operands are not affected by changes on op_* after acceptance.
- Carry wraps out of the top byte into cout only; result wraps modulo 2^(WIDTH*NBYTES).
- in_valid while busy is ignored. The requester holds its operands until in_ready.
- rst asserted in any state, including mid-RUN, returns the block to the reset values on the next edge. The partial result is discarded and no out_valid pulse is produced.

Optional Feature:
- Macro MBYTE_ADD_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit, reset 0).
  - In DONE, ovf = signed overflow = carry into MSB XOR carry out of MSB.
  - The carry into the MSB is taken as add_a[WIDTH-1] ^ add_b[WIDTH-1] ^ add_sum[WIDTH-1] on the last byte.
  - ovf is registered with result.
- When undefined: no ovf port and no overflow logic.

Test Plan:
- Add: A=0x000000FF, B=0x00000001, cin=0, sub=0 -> result=0x00000100, cout=0. out_valid rises exactly 4 cycles after the accept edge.
- Full carry chain: A=0xFFFFFFFF, B=0x00000001, cin=0 -> result=0x00000000, cout=1. A=0xAAAAAAAA, B=0x55555555, cin=1 -> result=0x00000000, cout=1.
- Subtract: A=0x00000005, B=0x00000007, sub=1 -> result=0xFFFFFFFE, cout=0. A=0x00000007, B=0x00000005 -> result=0x00000002, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. result and cout stay stable and in_ready=0. A second in_valid presented during this time is not accepted until one cycle after the handoff.
- Reset mid-operation: assert rst for 1 cycle during RUN byte 2 -> next cycle in_ready=1, out_valid=0, result=0. A subsequent op 0x12345678+0x11111111 yields 0x23456789.
- MBYTE_ADD_OVF_EN: 0x7FFFFFFF+0x00000001 -> ovf=1, cout=0. 0xFFFFFFFF+0x00000001 -> ovf=0, cout=1.
